alarm_clock_controller: RTL and testbench

- Front-end sequencing FSM for the alarm clock. It decodes keypad and button activity into the control strobes that drive lcd_driver (show_alarm, show_new_time) and the time/alarm registers (load_new_a, load_new_c).
- Owns the 4-digit keypad entry buffer and the entry-timeout counter.
- Sits between the keypad scanner and the lcd_driver / time-counter / alarm-register datapath.

---
 rtl/alarm_clock_controller.sv | 116 +++++++++++
 tb/tb_alarm_clock_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_controller.sv
// rtl/alarm_clock_controller.sv - keypad entry / alarm-time sequencing FSM for the alarm clock
module alarm_clock_controller #(
  parameter int         TIMEOUT_SEC = 10,
  parameter logic [3:0] NOKEY       = 4'hA
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        one_second,
  input  logic [3:0]  key,
  input  logic        alarm_button,
  input  logic        time_button,
  output logic [15:0] key_buffer,
  output logic        show_alarm,
  output logic        show_new_time,
  output logic        load_new_a,
  output logic        load_new_c,
  output logic        shift
);

  typedef enum logic [2:0] {
    IDLE,
    KEY_STORED,
    KEY_WAIT,
    KEY_ENTRY,
    SHOW_ALARM,
    SET_ALARM,
    SET_TIME
  } state_t;

  state_t      state, next_state;
  logic [3:0]  count, count_next;
  logic [15:0] buffer_next;
  logic        digit, timeout, entry_now, entry_next;

  // Codes above 9 (including the NOKEY code) all read as "nothing pressed".
  assign digit   = (key <= 4'd9) && (key != NOKEY);
  assign timeout = (count == 4'(TIMEOUT_SEC));

  // State, entry-timeout counter and keypad buffer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= 4'd0;
      key_buffer <= 16'h0000;
    end else begin
      state      <= next_state;
      count      <= count_next;
      key_buffer <= buffer_next;
    end
  end

  // Next-state selection from the current state and keypad/button inputs.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (digit)             next_state = KEY_STORED;
        else if (alarm_button) next_state = SHOW_ALARM;
      end
      KEY_STORED: next_state = KEY_WAIT;
      KEY_WAIT: begin
        if (timeout)     next_state = IDLE;
        else if (!digit) next_state = KEY_ENTRY;
      end
      KEY_ENTRY: begin
        if (alarm_button)     next_state = SET_ALARM;
        else if (time_button) next_state = SET_TIME;
        else if (digit)       next_state = KEY_STORED;
        else if (timeout)     next_state = IDLE;
      end
      SHOW_ALARM: begin
        if (!alarm_button) next_state = IDLE;
      end
      SET_ALARM: next_state = IDLE;
      SET_TIME:  next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Counter only runs while staying inside the waiting/entry pair of states;
  // any transition in or out of that pair restarts it from zero.
  always_comb begin
    entry_now  = (state == KEY_WAIT) || (state == KEY_ENTRY);
    entry_next = (next_state == KEY_WAIT) || (next_state == KEY_ENTRY);
    count_next = (entry_now && entry_next) ? count + {3'b000, one_second} : 4'd0;
  end

  // Buffer shifts once per stored digit and is discarded after a load or abandon.
  always_comb begin
    buffer_next = key_buffer;
    case (state)
      KEY_STORED:          buffer_next = {key_buffer[11:0], key};
      SET_ALARM, SET_TIME: buffer_next = 16'h0000;
      KEY_WAIT, KEY_ENTRY: if (next_state == IDLE) buffer_next = 16'h0000;
      default:             buffer_next = key_buffer;
    endcase
  end

  // Moore decode of the display selects and one-cycle strobes.
  always_comb begin
    shift         = 1'b0;
    show_new_time = 1'b0;
    show_alarm    = 1'b0;
    load_new_a    = 1'b0;
    load_new_c    = 1'b0;
    case (state)
      KEY_STORED:          shift         = 1'b1;
      KEY_WAIT, KEY_ENTRY: show_new_time = 1'b1;
      SHOW_ALARM:          show_alarm    = 1'b1;
      SET_ALARM:           load_new_a    = 1'b1;
      SET_TIME:            load_new_c    = 1'b1;
      default:             shift         = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alarm_clock_controller.sv
// tb/tb_alarm_clock_controller.sv - directed bench with behavioural model for alarm_clock_controller
module tb_alarm_clock_controller;

  localparam int T = 10;

  logic        clock = 1'b0;
  logic        reset;
  logic        one_second;
  logic [3:0]  key;
  logic        alarm_button;
  logic        time_button;
  logic [15:0] key_buffer;
  logic        show_alarm;
  logic        show_new_time;
  logic        load_new_a;
  logic        load_new_c;
  logic        shift;

  int vectors     = 0;
  int miscompares = 0;
  int shift_cnt   = 0;
  int load_a_cnt  = 0;
  int load_c_cnt  = 0;

  alarm_clock_controller #(.TIMEOUT_SEC(T), .NOKEY(4'hA)) dut (
    .clock         (clock),
    .reset         (reset),
    .one_second    (one_second),
    .key           (key),
    .alarm_button  (alarm_button),
    .time_button   (time_button),
    .key_buffer    (key_buffer),
    .show_alarm    (show_alarm),
    .show_new_time (show_new_time),
    .load_new_a    (load_new_a),
    .load_new_c    (load_new_c),
    .shift         (shift)
  );

  always #5 clock = ~clock;

  // Behavioural model: entry session flags, pending strobes and elapsed seconds.
  logic [15:0] m_buffer;
  int          m_secs;
  int          m_load;
  bit          m_entry, m_held, m_pend_shift, m_view;
  wire         is_digit = (key <= 4'd9);

  // Advance the model one clock using the rules of the entry session.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_buffer <= 16'h0000; m_secs <= 0; m_load <= 0;
      m_entry <= 0; m_held <= 0; m_pend_shift <= 0; m_view <= 0;
    end else if (m_pend_shift) begin
      m_buffer <= {m_buffer[11:0], key};
      m_pend_shift <= 0; m_entry <= 1; m_held <= 1; m_secs <= 0;
    end else if (m_load != 0) begin
      m_buffer <= 16'h0000; m_load <= 0;
    end else if (m_view) begin
      m_view <= alarm_button;
    end else if (m_entry) begin
      if (m_held) begin
        if (m_secs == T) begin
          m_entry <= 0; m_held <= 0; m_buffer <= 16'h0000; m_secs <= 0;
        end else begin
          m_secs <= m_secs + int'(one_second);
          if (!is_digit) m_held <= 0;
        end
      end else if (alarm_button) begin
        m_entry <= 0; m_load <= 1; m_secs <= 0;
      end else if (time_button) begin
        m_entry <= 0; m_load <= 2; m_secs <= 0;
      end else if (is_digit) begin
        m_entry <= 0; m_pend_shift <= 1; m_secs <= 0;
      end else if (m_secs == T) begin
        m_entry <= 0; m_buffer <= 16'h0000; m_secs <= 0;
      end else begin
        m_secs <= m_secs + int'(one_second);
      end
    end else begin
      if (is_digit)          m_pend_shift <= 1;
      else if (alarm_button) m_view <= 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (!reset) begin
      vectors++;
      if (key_buffer !== m_buffer || shift !== m_pend_shift || show_new_time !== m_entry ||
          show_alarm !== m_view || load_new_a !== (m_load == 1) || load_new_c !== (m_load == 2)) begin
        miscompares++;
        $display("FAIL cycle t=%0t got buf=%h sh=%b snt=%b sa=%b la=%b lc=%b want buf=%h sh=%b snt=%b sa=%b la=%b lc=%b",
                 $time, key_buffer, shift, show_new_time, show_alarm, load_new_a, load_new_c,
                 m_buffer, m_pend_shift, m_entry, m_view, m_load == 1, m_load == 2);
      end
      shift_cnt  += int'(shift);
      load_a_cnt += int'(load_new_a);
      load_c_cnt += int'(load_new_c);
    end
  end

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string name);
    check16(name, {key_buffer[15:0]}, 16'h0000);
    check16({name, "_outs"}, {11'd0, shift, show_new_time, show_alarm, load_new_a, load_new_c}, 16'h0000);
  endtask

  task automatic press(input logic [3:0] d, input int hold);
    key = d;
    repeat (hold) @(negedge clock);
    key = 4'hA;
    repeat (2) @(negedge clock);
  endtask

  int s0, la0, lc0;

  initial begin
    reset = 1'b1; one_second = 1'b0; key = 4'hA; alarm_button = 1'b0; time_button = 1'b0;
    repeat (2) @(negedge clock);
    check_quiet("reset_state");
    reset = 1'b0;
    @(negedge clock);

    // Asynchronous reset in the middle of an entry.
    press(4'd1, 3);
    press(4'd2, 3);
    check16("partial_buf", key_buffer, 16'h0012);
    #2 reset = 1'b1;
    #1 check_quiet("async_reset");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Enter 1,2,3,0 and load as current time.
    s0 = shift_cnt; lc0 = load_c_cnt;
    press(4'd1, 3); press(4'd2, 3); press(4'd3, 3); press(4'd0, 3);
    check_int("time_shift_pulses", shift_cnt - s0, 4);
    check16("time_buf", key_buffer, 16'h1230);
    time_button = 1'b1;
    @(negedge clock);
    check16("load_c_high", {15'd0, load_new_c}, 16'h0001);
    check16("load_c_buf", key_buffer, 16'h1230);
    time_button = 1'b0;
    @(negedge clock);
    check16("after_time_buf", key_buffer, 16'h0000);
    check16("after_time_snt", {15'd0, show_new_time}, 16'h0000);
    check_int("load_c_once", load_c_cnt - lc0, 1);

    // Enter 0,6,4,5 and load as alarm.
    la0 = load_a_cnt;
    press(4'd0, 3); press(4'd6, 3); press(4'd4, 3); press(4'd5, 3);
    alarm_button = 1'b1;
    @(negedge clock);
    check16("load_a_high", {15'd0, load_new_a}, 16'h0001);
    check16("load_a_buf", key_buffer, 16'h0645);
    alarm_button = 1'b0;
    @(negedge clock);
    check_int("load_a_once", load_a_cnt - la0, 1);

    // Digit 7 then silence until timeout.
    la0 = load_a_cnt; lc0 = load_c_cnt;
    press(4'd7, 3);
    for (int i = 0; i < T - 1; i++) begin
      one_second = 1'b1; @(negedge clock);
      one_second = 1'b0; @(negedge clock);
    end
    check16("pre_timeout_snt", {15'd0, show_new_time}, 16'h0001);
    one_second = 1'b1; @(negedge clock);
    check16("tick10_snt", {15'd0, show_new_time}, 16'h0001);
    one_second = 1'b0; @(negedge clock);
    check_quiet("timeout_idle");
    check_int("timeout_no_load", (load_a_cnt - la0) + (load_c_cnt - lc0), 0);

    // Alarm display held for 5 cycles; a digit meanwhile does nothing.
    s0 = shift_cnt;
    alarm_button = 1'b1;
    @(negedge clock);
    check16("show_alarm_on", {15'd0, show_alarm}, 16'h0001);
    key = 4'd4; repeat (2) @(negedge clock);
    key = 4'hA; repeat (2) @(negedge clock);
    check16("show_alarm_held", {15'd0, show_alarm}, 16'h0001);
    alarm_button = 1'b0;
    @(negedge clock);
    check16("show_alarm_off", {15'd0, show_alarm}, 16'h0000);
    check_int("alarm_view_no_shift", shift_cnt - s0, 0);

    // Long-held digit 9 shifts once; code B is ignored.
    s0 = shift_cnt;
    press(4'd9, 20);
    check_int("held9_shift", shift_cnt - s0, 1);
    check16("held9_buf", key_buffer, 16'h0009);
    key = 4'hB; repeat (3) @(negedge clock);
    check_int("keyB_no_shift", shift_cnt - s0, 1);
    check16("keyB_snt", {15'd0, show_new_time}, 16'h0001);

    // Tick coincident with a digit: counter restarts from zero.
    key = 4'd3; one_second = 1'b1;
    @(negedge clock);
    one_second = 1'b0;
    check16("tick_digit_shift", {15'd0, shift}, 16'h0001);
    @(negedge clock);
    key = 4'hA; repeat (2) @(negedge clock);
    check16("buf_93", key_buffer, 16'h0093);
    for (int i = 0; i < T - 1; i++) begin
      one_second = 1'b1; @(negedge clock);
      one_second = 1'b0; @(negedge clock);
    end
    check16("counter_restarted", {15'd0, show_new_time}, 16'h0001);
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
